jls_bit_packer: RTL

Final stage of the LOCO-I/JPEG-LS encoder pipeline, directly downstream of the run/regular parameter delay stage. Consumes the registered run-code stream (`codes_r`/`codes_r_len`) and the regular-mode Golomb parameters (`k`, `glimit`, `EMErrval`). It builds limited-length Golomb codewords, appends all code bits MSB-first into a bit accumulator, and drains it as a byte stream with a valid/ready handshake and optional 0xFF bit stuffing.

---
 rtl/jls_bit_packer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/jls_bit_packer.sv
// jls_bit_packer: packs run codes and limited-length Golomb codewords MSB-first into a byte stream.
// Latency: input presented before edge t+1 is in stage 1 after t+1 and in the accumulator after t+2; drains 1 byte/cycle.
// Backpressure: byte_out is held while byte_valid && !byte_ready; input that would exceed ACC_W is dropped and sets overflow.
// Build option: define JLS_PACKER_STUFF_EN to insert a zero MSB in the byte following every transferred 0xFF.
module jls_bit_packer #(
    parameter int QBPP  = 8,
    parameter int ACC_W = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] codes_r_in,
    input  logic [5:0]  codes_r_len_in,
    input  logic        en_out1_in,
    input  logic [4:0]  k_in,
    input  logic [5:0]  glimit_in,
    input  logic [8:0]  EMErrval_in,
    input  logic        en_out2_in,
    input  logic        flush_in,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        busy,
    output logic        flush_done,
    output logic        overflow
);
    localparam int CNT_W = $clog2(ACC_W + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_PAD, ST_DRAIN} state_t;

    state_t             state_q;
    logic               busy_q, flush_done_q, overflow_q;
    logic               s1_run_vld_q, s1_gol_vld_q;
    logic [31:0]        s1_run_dat_q, s1_gol_dat_q;
    logic [5:0]         s1_run_len_q, s1_gol_len_q;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [8:0]         gol_q;
    logic [9:0]         gol_lim;
    logic [31:0]        gol_dat_d;
    logic [5:0]         gol_len_d;
    logic               in_drop;

    logic               stuff_pend, stuff_d, xfer, app_ovf;
    logic [CNT_W-1:0]   need, need_nx, drain_len, cnt_dr, in_len, pad_len;
    logic [5:0]         run_len_v, gol_len_v;
    logic [31:0]        run_mask;
    logic [ACC_W-1:0]   acc_dr, run_ext, gol_ext, in_bits;
    logic [CNT_W:0]     cnt_sum, shamt;

    // Limited-length Golomb codeword: leading zeros are implied by the length.
    always_comb begin
        gol_q   = (k_in >= 5'd9) ? 9'd0 : (EMErrval_in >> k_in);
        gol_lim = {4'd0, glimit_in} - 10'(QBPP + 1);
        if ({1'b0, gol_q} < gol_lim) begin
            gol_dat_d = (32'd1 << k_in) | ({23'd0, EMErrval_in} & ((32'd1 << k_in) - 32'd1));
            gol_len_d = 6'(gol_q) + 6'(k_in) + 6'd1;
        end else begin
            gol_dat_d = (32'd1 << QBPP) | (({23'd0, EMErrval_in} - 32'd1) & ((32'd1 << QBPP) - 32'd1));
            gol_len_d = glimit_in;
        end
    end

    // Inputs arriving during a flush are not accepted.
    assign in_drop = busy_q && (en_out1_in || en_out2_in);

    // Stage 1: register run code and Golomb codeword side by side so ordering is preserved.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_run_vld_q <= 1'b0;
            s1_run_dat_q <= '0;
            s1_run_len_q <= '0;
            s1_gol_vld_q <= 1'b0;
            s1_gol_dat_q <= '0;
            s1_gol_len_q <= '0;
        end else begin
            s1_run_vld_q <= en_out1_in && !busy_q;
            s1_gol_vld_q <= en_out2_in && !busy_q;
            if (en_out1_in && !busy_q) begin
                s1_run_dat_q <= codes_r_in;
                s1_run_len_q <= codes_r_len_in;
            end
            if (en_out2_in && !busy_q) begin
                s1_gol_dat_q <= gol_dat_d;
                s1_gol_len_q <= gol_len_d;
            end
        end
    end

    // Output byte view: a stuffed byte takes only 7 accumulator bits behind a forced zero.
    assign need       = stuff_pend ? CNT_W'(7) : CNT_W'(8);
    assign byte_valid = (cnt_q >= need);
    assign byte_out   = stuff_pend ? {1'b0, acc_q[ACC_W-1 -: 7]} : acc_q[ACC_W-1 -: 8];
    assign xfer       = byte_valid && byte_ready;

`ifdef JLS_PACKER_STUFF_EN
    logic stuff_q;
    assign stuff_pend = stuff_q;
    assign stuff_d    = xfer ? (byte_out == 8'hFF) : stuff_q;

    // Remember that the last transferred byte was 0xFF.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stuff_q <= 1'b0;
        else        stuff_q <= stuff_d;
    end
`else
    assign stuff_pend = 1'b0;
    assign stuff_d    = 1'b0;
`endif

    // Stage 2: drain from the top, append new bits just below the remaining ones.
    always_comb begin
        need_nx   = stuff_d ? CNT_W'(7) : CNT_W'(8);
        drain_len = xfer ? need : '0;
        acc_dr    = acc_q << drain_len;
        cnt_dr    = cnt_q - drain_len;
        run_len_v = s1_run_vld_q ? s1_run_len_q : 6'd0;
        gol_len_v = s1_gol_vld_q ? s1_gol_len_q : 6'd0;
        in_len    = CNT_W'(run_len_v) + CNT_W'(gol_len_v);
        run_mask  = (run_len_v >= 6'd32) ? '1 : ((32'd1 << run_len_v) - 32'd1);
        run_ext   = ACC_W'(s1_run_dat_q & run_mask);
        gol_ext   = s1_gol_vld_q ? ACC_W'(s1_gol_dat_q) : '0;
        in_bits   = (run_ext << gol_len_v) | gol_ext;
        cnt_sum   = {1'b0, cnt_q} + {1'b0, in_len};
        app_ovf   = (cnt_sum > (CNT_W + 1)'(ACC_W));
        // Padding is resolved only on the final partial byte, since a stuffed byte moves the boundary.
        pad_len   = '0;
        if ((state_q == ST_PAD || state_q == ST_DRAIN) && cnt_dr != '0 && cnt_dr < need_nx)
            pad_len = need_nx - cnt_dr;
        shamt     = '0;
        if (app_ovf) begin
            acc_d = acc_dr;
            cnt_d = cnt_dr + pad_len;
        end else begin
            shamt = (CNT_W + 1)'(ACC_W) - {1'b0, cnt_dr} - {1'b0, in_len};
            acc_d = acc_dr | (in_bits << shamt);
            cnt_d = cnt_dr + in_len + pad_len;
        end
    end

    // Accumulator, bit count and sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_q | app_ovf | in_drop;
        end
    end

    // Flush sequencing: let stage 1 land, pad, then wait for the accumulator to empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (flush_in) begin
                    state_q <= ST_WAIT;
                    busy_q  <= 1'b1;
                end
                ST_WAIT: state_q <= ST_PAD;
                ST_PAD:  state_q <= ST_DRAIN;
                ST_DRAIN: if (cnt_q == '0) begin
                    state_q      <= ST_IDLE;
                    busy_q       <= 1'b0;
                    flush_done_q <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign flush_done = flush_done_q;
    assign overflow   = overflow_q;

endmodule
